// File: rtl/sub_pkg.sv
// Shared state encoding for the bit-serial arithmetic blocks.
package sub_pkg;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} sub_state_t;
endpackage

// File: rtl/subtractor.sv
// WIDTH-bit full subtractor, purely combinational, zero latency.
// No handshake; used as the per-bit cell of the serial datapath.
module subtractor #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bout
);
   assign {bout, d} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial N-bit subtractor, LSB first; done pulses N+1 cycles after an accepted start.
// ready is high only in IDLE; start while busy is dropped, not queued.
module serial_subtractor_ctrl
   import sub_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         borrow_in,
   output logic         ready,
   output logic [N-1:0] diff,
   output logic         borrow_out,
   output logic         done
);
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   sub_state_t       state;
   sub_state_t       state_nxt;
   logic [N-1:0]     a_sr;
   logic [N-1:0]     b_sr;
   logic [N-1:0]     res_sr;
   logic [N-1:0]     res_nxt;
   logic [CNT_W-1:0] cnt;
   logic             brw;
   logic             cell_d;
   logic             cell_bout;

   subtractor #(.WIDTH(1)) u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (brw),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // Difference bits enter at the MSB so the LSB lands at bit 0 after N shifts.
   generate
      if (N == 1) begin : g_one
         assign res_nxt = cell_d;
      end else begin : g_wide
         assign res_nxt = {cell_d, res_sr[N-1:1]};
      end
   endgenerate

   assign ready = (state == S_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SHIFT;
         S_SHIFT: if (cnt == CNT_LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         cnt        <= '0;
         brw        <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sr <= a_in;
                  b_sr <= b_in;
                  brw  <= borrow_in;
                  cnt  <= '0;
               end
            end
            S_SHIFT: begin
               brw    <= cell_bout;
               res_sr <= res_nxt;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               cnt    <= cnt + CNT_W'(1);
            end
            S_DONE: begin
               diff       <= res_sr;
               borrow_out <= brw;
               done       <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Drives an N=8 and an N=1 instance from shared stimulus; a driver-side ready model pushes
// expected results, and a negedge monitor pops them on done and checks hold/reset behaviour.
module tb_serial_subtractor_ctrl;
   typedef struct {
      logic [15:0] d;
      logic        br;
      int          due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       borrow_in;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       rdy8, brw8, done8;
   logic [7:0] diff8;
   logic       rdy1, brw1, done1;
   logic [0:0] diff1;

   always #5 clk = ~clk;

   serial_subtractor_ctrl #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .borrow_in(borrow_in),
      .ready(rdy8), .diff(diff8), .borrow_out(brw8), .done(done8)
   );

   serial_subtractor_ctrl #(.N(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in[0]), .b_in(b_in[0]), .borrow_in(borrow_in),
      .ready(rdy1), .diff(diff1), .borrow_out(brw1), .done(done1)
   );

   int   cyc = 0;
   logic rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   exp_t        q8[$];
   exp_t        q1[$];
   int          busy[2];
   bit          acc[2];
   bit          exp_rdy[2];
   bit          prev_rst;
   logic [15:0] held_d[2];
   logic        held_b[2];
   int          checks = 0;
   int          failures = 0;

   function automatic int nbits(input int i);
      return (i == 0) ? 8 : 1;
   endfunction

   function automatic exp_t ref_model(input int i, input logic [7:0] a, input logic [7:0] b,
                                      input logic bin, input int due);
      logic [8:0] r8;
      logic [1:0] r1;
      exp_t       e;
      if (i == 0) begin
         r8   = {1'b0, a} - {1'b0, b} - {8'd0, bin};
         e.d  = {8'd0, r8[7:0]};
         e.br = r8[8];
      end else begin
         r1   = {1'b0, a[0]} - {1'b0, b[0]} - {1'b0, bin};
         e.d  = {15'd0, r1[0]};
         e.br = r1[1];
      end
      e.due = due;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, expv, cyc);
      end
   endtask

   // One clock of stimulus; inputs change just after the edge so they are stable at the next one.
   task automatic drive(input bit st, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input bit r, input bit hand, input logic [7:0] ed, input logic eb);
      exp_t e;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (prev_rst)     busy[i] = 0;
         else if (acc[i])  busy[i] = nbits(i) + 1;
         else if (busy[i] > 0) busy[i]--;
      end
      if (prev_rst) begin
         q8.delete();
         q1.delete();
      end
      start = st; a_in = a; b_in = b; borrow_in = bin; rst = r; prev_rst = r;
      for (int i = 0; i < 2; i++) begin
         exp_rdy[i] = (busy[i] == 0);
         acc[i]     = st && !r && (busy[i] == 0);
      end
      if (acc[0]) begin
         e = ref_model(0, a, b, bin, cyc + nbits(0) + 2);
         if (hand) begin
            e.d  = {8'd0, ed};
            e.br = eb;
         end
         q8.push_back(e);
      end
      if (acc[1]) q1.push_back(ref_model(1, a, b, bin, cyc + nbits(1) + 2));
   endtask

   task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb);
      do drive(1'b1, a, b, bin, 1'b0, 1'b1, ed, eb); while (!acc[0]);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   task automatic mon(input int i, input logic [15:0] d, input logic br, input logic dn,
                      input logic rd);
      exp_t  e;
      string nm;
      int    qs;
      nm = (i == 0) ? "n8" : "n1";
      qs = (i == 0) ? q8.size() : q1.size();
      check({nm, "_ready"}, 32'(rd), 32'(exp_rdy[i]));
      if (rst_q) begin
         check({nm, "_reset_diff"}, 32'(d), 32'd0);
         check({nm, "_reset_borrow"}, 32'(br), 32'd0);
         check({nm, "_reset_done"}, 32'(dn), 32'd0);
         held_d[i] = '0;
         held_b[i] = 1'b0;
      end else if (dn) begin
         if (qs == 0) begin
            check({nm, "_spurious_done"}, 32'(dn), 32'd0);
         end else begin
            e = (i == 0) ? q8.pop_front() : q1.pop_front();
            check({nm, "_diff"}, 32'(d), 32'(e.d));
            check({nm, "_borrow"}, 32'(br), 32'(e.br));
            check({nm, "_latency"}, cyc, e.due);
            held_d[i] = e.d;
            held_b[i] = e.br;
         end
      end else begin
         check({nm, "_hold_diff"}, 32'(d), 32'(held_d[i]));
         check({nm, "_hold_borrow"}, 32'(br), 32'(held_b[i]));
         if (qs > 0) begin
            e = (i == 0) ? q8[0] : q1[0];
            if (cyc > e.due) begin
               check({nm, "_done_missing"}, cyc, e.due);
               if (i == 0) void'(q8.pop_front());
               else        void'(q1.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, {8'd0, diff8}, brw8, done8, rdy8);
      mon(1, {15'd0, diff1}, brw1, done1, rdy1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; borrow_in = 1'b0;
      prev_rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         busy[i] = 0; acc[i] = 1'b0; exp_rdy[i] = 1'b1; held_d[i] = '0; held_b[i] = 1'b0;
      end
      drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      idle(2);

      // Directed vectors with hand-computed results; start stays high while busy.
      op(8'd200, 8'd55,  1'b0, 8'd145, 1'b0);
      op(8'd5,   8'd10,  1'b0, 8'd251, 1'b1);
      op(8'd0,   8'd0,   1'b1, 8'd255, 1'b1);
      op(8'd255, 8'd255, 1'b0, 8'd0,   1'b0);
      op(8'd0,   8'd1,   1'b0, 8'd255, 1'b1);
      op(8'd128, 8'd127, 1'b1, 8'd0,   1'b0);
      op(8'd100, 8'd100, 1'b1, 8'd255, 1'b1);
      op(8'd1,   8'd0,   1'b0, 8'd1,   1'b0);
      idle(12);

      // Continuous start with operands changing every cycle.
      for (int k = 0; k < 45; k++)
         drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 8'd0, 1'b0);
      idle(12);

      // Reset during the fourth SHIFT cycle aborts without a done pulse.
      op(8'd77, 8'd33, 1'b0, 8'd44, 1'b0);
      idle(3);
      drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      idle(14);

      // Start coinciding with reset is lost.
      drive(1'b1, 8'd9, 8'd3, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      idle(14);
      op(8'd9, 8'd3, 1'b0, 8'd6, 1'b0);
      idle(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
